// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared widths, 2-bit counter encodings and saturating helpers
package branch_predictor_pkg;

   localparam int BP_ADDR_WIDTH = 16;

   localparam logic [1:0] BP_SNT = 2'b00;
   localparam logic [1:0] BP_WNT = 2'b01;
   localparam logic [1:0] BP_WT  = 2'b10;
   localparam logic [1:0] BP_ST  = 2'b11;

   function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
      return (ctr == BP_ST) ? BP_ST : ctr + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
      return (ctr == BP_SNT) ? BP_SNT : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/branch_predictor_btb_table.sv
// rtl/branch_predictor_btb_table.sv - BTB storage: two async read ports, one sync write, sync bulk clear
module btb_table
   import branch_predictor_pkg::*;
#(
   parameter int ADDR_WIDTH = BP_ADDR_WIDTH,
   parameter int INDEX_BITS = 4,
   parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INDEX_BITS-1:0] fetch_index,
   output logic                  fetch_valid,
   output logic [TAG_BITS-1:0]   fetch_tag,
   output logic [ADDR_WIDTH-1:0] fetch_target,
   output logic [1:0]            fetch_ctr,
   input  logic [INDEX_BITS-1:0] res_index,
   output logic                  res_valid,
   output logic [TAG_BITS-1:0]   res_tag,
   output logic [ADDR_WIDTH-1:0] res_target,
   output logic [1:0]            res_ctr,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [ADDR_WIDTH-1:0] wr_target,
   input  logic [1:0]            wr_ctr
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic                  valid_q  [ENTRIES];
   logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
   logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
   logic [1:0]            ctr_q    [ENTRIES];

   assign fetch_valid  = valid_q[fetch_index];
   assign fetch_tag    = tag_q[fetch_index];
   assign fetch_target = target_q[fetch_index];
   assign fetch_ctr    = ctr_q[fetch_index];

   assign res_valid  = valid_q[res_index];
   assign res_tag    = tag_q[res_index];
   assign res_target = target_q[res_index];
   assign res_ctr    = ctr_q[res_index];

   // Only valid and ctr are cleared; stale tag/target are unreachable once valid is 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= BP_SNT;
         end
      end else if (wr_en) begin
         valid_q[wr_index]  <= 1'b1;
         tag_q[wr_index]    <= wr_tag;
         target_q[wr_index] <= wr_target;
         ctr_q[wr_index]    <= wr_ctr;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB predictor top: lookup, counter update, flush; BRANCH_PREDICTOR_STATS_EN adds counters
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ADDR_WIDTH = BP_ADDR_WIDTH,
   parameter int INDEX_BITS = 4,
   parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] fetch_pc,
   output logic                  take_branch,
   output logic [ADDR_WIDTH-1:0] branch_predict,
   input  logic                  res_valid,
   input  logic [ADDR_WIDTH-1:0] res_pc,
   input  logic                  res_taken,
   input  logic [ADDR_WIDTH-1:0] res_target,
   input  logic                  res_pred_taken,
   input  logic [ADDR_WIDTH-1:0] res_pred_target,
`ifdef BRANCH_PREDICTOR_STATS_EN
   output logic [15:0]           stat_resolved,
   output logic [15:0]           stat_mispredict,
`endif
   output logic                  flush,
   output logic [ADDR_WIDTH-1:0] flush_address
);

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(2);

   logic                  f_valid, r_valid;
   logic [TAG_BITS-1:0]   f_tag, r_tag;
   logic [ADDR_WIDTH-1:0] f_target, r_target;
   logic [1:0]            f_ctr, r_ctr;
   logic                  f_hit, r_hit;
   logic                  res_ok, mispredict;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_target;
   logic [1:0]            wr_ctr;

   btb_table #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_table (
      .clk          (clk),
      .reset        (reset),
      .fetch_index  (fetch_pc[INDEX_BITS:1]),
      .fetch_valid  (f_valid),
      .fetch_tag    (f_tag),
      .fetch_target (f_target),
      .fetch_ctr    (f_ctr),
      .res_index    (res_pc[INDEX_BITS:1]),
      .res_valid    (r_valid),
      .res_tag      (r_tag),
      .res_target   (r_target),
      .res_ctr      (r_ctr),
      .wr_en        (wr_en),
      .wr_index     (res_pc[INDEX_BITS:1]),
      .wr_tag       (res_pc[ADDR_WIDTH-1:INDEX_BITS+1]),
      .wr_target    (wr_target),
      .wr_ctr       (wr_ctr)
   );

   assign f_hit          = f_valid && (f_tag == fetch_pc[ADDR_WIDTH-1:INDEX_BITS+1]);
   assign r_hit          = r_valid && (r_tag == res_pc[ADDR_WIDTH-1:INDEX_BITS+1]);
   assign take_branch    = !reset && f_hit && f_ctr[1];
   assign branch_predict = f_hit ? f_target : fetch_pc + PC_STEP;

   // A resolve arriving while flush is high belongs to a wrong-path instruction.
   assign res_ok     = res_valid && !reset && !flush;
   assign mispredict = res_ok && ((res_taken != res_pred_taken) ||
                       (res_taken && res_pred_taken && (res_target != res_pred_target)));

   always_comb begin
      wr_en     = 1'b0;
      wr_target = res_target;
      wr_ctr    = r_ctr;
      if (res_ok) begin
         if (res_taken) begin
            wr_en  = 1'b1;
            wr_ctr = r_hit ? sat_inc(r_ctr) : BP_WT;
         end else if (r_hit) begin
            wr_en     = 1'b1;
            wr_target = r_target;
            wr_ctr    = sat_dec(r_ctr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flush         <= 1'b0;
         flush_address <= '0;
      end else begin
         flush <= mispredict;
         if (mispredict)
            flush_address <= res_taken ? res_target : res_pc + PC_STEP;
      end
   end

`ifdef BRANCH_PREDICTOR_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_resolved   <= '0;
         stat_mispredict <= '0;
      end else begin
         if (res_ok && stat_resolved != 16'hFFFF)
            stat_resolved <= stat_resolved + 16'd1;
         if (mispredict && stat_mispredict != 16'hFFFF)
            stat_mispredict <= stat_mispredict + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
`timescale 1ns/1ps
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] fetch_pc;
   logic        take_branch;
   logic [15:0] branch_predict;
   logic        res_valid;
   logic [15:0] res_pc;
   logic        res_taken;
   logic [15:0] res_target;
   logic        res_pred_taken;
   logic [15:0] res_pred_target;
   logic        flush;
   logic [15:0] flush_address;
`ifdef BRANCH_PREDICTOR_STATS_EN
   logic [15:0] stat_resolved;
   logic [15:0] stat_mispredict;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk             (clk),
      .reset           (reset),
      .fetch_pc        (fetch_pc),
      .take_branch     (take_branch),
      .branch_predict  (branch_predict),
      .res_valid       (res_valid),
      .res_pc          (res_pc),
      .res_taken       (res_taken),
      .res_target      (res_target),
      .res_pred_taken  (res_pred_taken),
      .res_pred_target (res_pred_target),
`ifdef BRANCH_PREDICTOR_STATS_EN
      .stat_resolved   (stat_resolved),
      .stat_mispredict (stat_mispredict),
`endif
      .flush           (flush),
      .flush_address   (flush_address)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resolve(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                          input logic ptk, input logic [15:0] ptgt);
      res_valid       = 1'b1;
      res_pc          = pc;
      res_taken       = tk;
      res_target      = tgt;
      res_pred_taken  = ptk;
      res_pred_target = ptgt;
   endtask

   task automatic idle();
      res_valid = 1'b0;
   endtask

   task automatic look(input string tag, input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
      fetch_pc = pc;
      #1;
      chk({tag, "_take"}, 32'(take_branch), 32'(tk));
      chk({tag, "_pred"}, 32'(branch_predict), 32'(tgt));
   endtask

   initial begin
      reset = 1'b1;
      fetch_pc = 16'h0010;
      resolve(16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
      idle();
      tick();
      tick();
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_faddr", 32'(flush_address), 32'h0);
      look("rst", 16'h0010, 1'b0, 16'h0012);

      reset = 1'b0;
      tick();
      look("cold", 16'h0010, 1'b0, 16'h0012);

      // allocate; same-cycle lookup still sees the old (empty) entry
      resolve(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
      look("same_cycle", 16'h0010, 1'b0, 16'h0012);
      tick();
      idle();
      chk("alloc_flush", 32'(flush), 32'd1);
      chk("alloc_faddr", 32'(flush_address), 32'h0040);
      look("alloc", 16'h0010, 1'b1, 16'h0040);
      tick();
      chk("alloc_flush_off", 32'(flush), 32'd0);

      // saturate to strong-taken with correct predictions
      for (int i = 0; i < 3; i++) begin
         resolve(16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
         tick();
         chk("sat_noflush", 32'(flush), 32'd0);
      end
      idle();
      look("sat_st", 16'h0010, 1'b1, 16'h0040);

      resolve(16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0040);
      tick();
      idle();
      chk("nt1_flush", 32'(flush), 32'd1);
      chk("nt1_faddr", 32'(flush_address), 32'h0012);
      look("nt1_wt", 16'h0010, 1'b1, 16'h0040);
      tick();
      resolve(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000);
      tick();
      idle();
      chk("nt2_noflush", 32'(flush), 32'd0);
      look("nt2_wnt", 16'h0010, 1'b0, 16'h0040);

      // alias: same index, different tag replaces the entry
      resolve(16'h0030, 1'b1, 16'h0080, 1'b0, 16'h0000);
      tick();
      idle();
      chk("alias_flush", 32'(flush), 32'd1);
      chk("alias_faddr", 32'(flush_address), 32'h0080);
      look("alias_old", 16'h0010, 1'b0, 16'h0012);
      look("alias_new", 16'h0030, 1'b1, 16'h0080);
      tick();

      // target mismatch, then a wrong-path resolve in the flush cycle
      resolve(16'h0030, 1'b1, 16'h0050, 1'b1, 16'h0040);
      tick();
      chk("tgt_flush", 32'(flush), 32'd1);
      chk("tgt_faddr", 32'(flush_address), 32'h0050);
      resolve(16'h0030, 1'b1, 16'h0060, 1'b0, 16'h0000);
      tick();
      idle();
      chk("ignored_noflush", 32'(flush), 32'd0);
      chk("ignored_faddr", 32'(flush_address), 32'h0050);
      look("ignored_tgt", 16'h0030, 1'b1, 16'h0050);
      tick();

      // wrap at top of address space, then reset while flush is high
      resolve(16'hFFFE, 1'b0, 16'h0000, 1'b1, 16'h1234);
      tick();
      chk("wrap_flush", 32'(flush), 32'd1);
      chk("wrap_faddr", 32'(flush_address), 32'h0000);
      reset = 1'b1;
      resolve(16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0000);
      tick();
      chk("rstmid_flush", 32'(flush), 32'd0);
      chk("rstmid_faddr", 32'(flush_address), 32'h0000);
      tick();
      chk("rstres_flush", 32'(flush), 32'd0);
      reset = 1'b0;
      idle();
      tick();
      chk("post_rst_flush", 32'(flush), 32'd0);
      look("post_rst_30", 16'h0030, 1'b0, 16'h0032);
      look("post_rst_40", 16'h0040, 1'b0, 16'h0042);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Drives `take_branch` / `branch_predict` into the fetch-stage program counter.
- Takes branch resolution from execute; updates the table.
- On a misprediction, generates the `flush` / `flush_address` pair consumed by the program counter.
- Sits between fetch (PC) and execute (branch unit); sequences all PC redirection except unconditional JMP.

Parameters:
- ADDR_WIDTH, 16, instruction address width; matches the `ADDR_WIDTH` define.
- INDEX_BITS, 4, log2 of BTB entries (default 16 entries).
- TAG_BITS, ADDR_WIDTH-INDEX_BITS-1, tag width; pc[0] is always 0, so it is excluded.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_pc  in  ADDR_WIDTH  current PC from program counter
- take_branch  out  1  prediction: branch at fetch_pc is taken
- branch_predict  out  ADDR_WIDTH  predicted target for fetch_pc
- res_valid  in  1  execute stage resolving a conditional branch this cycle
- res_pc  in  ADDR_WIDTH  address of the resolving branch
- res_taken  in  1  actual outcome
- res_target  in  ADDR_WIDTH  actual taken target
- res_pred_taken  in  1  prediction used for this branch (piped `branch_taken`)
- res_pred_target  in  ADDR_WIDTH  target used if predicted taken (piped)
- flush  out  1  one-cycle redirect pulse to program counter
- flush_address  out  ADDR_WIDTH  corrected PC

Behaviour:
- **Entry contents:** valid (1), tag (TAG_BITS), target (ADDR_WIDTH), ctr (2).
  - Index = pc[INDEX_BITS:1]; tag = pc[ADDR_WIDTH-1:INDEX_BITS+1].
- **Lookup (combinational from fetch_pc, zero latency):**
  - hit = valid && tag match.
  - take_branch = hit && ctr[1]; branch_predict = hit ? target : fetch_pc+2.
  - Forced take_branch=0 while reset=1.
- **Counter encoding:** 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Increments and decrements saturate at 11 / 00; no wrap.
- **Update on posedge when res_valid=1:**
  - Taken, hit: ctr++ (saturating), target <= res_target.
  - Taken, miss: allocate; overwrite valid=1, tag, target=res_target, ctr=10.
  - Not taken, hit: ctr-- (saturating).
  - Not taken, miss: no change (no allocation).
- **Same-cycle update and lookup to the same index:** lookup returns pre-update contents; the new value is visible the next cycle.
- **Mispredict** = res_valid && ((res_taken != res_pred_taken) || (res_taken && res_pred_taken && res_target != res_pred_target)).
- **Flush timing:** registered; flush=1 exactly one cycle after the mispredicting resolve, then 0.
  - flush_address = res_taken ? res_target : res_pc+2, captured with flush.
  - Arithmetic is ADDR_WIDTH-bit, wrapping; 16'hFFFE+2 = 0.
- **Back-to-back resolves:** res_valid in the cycle flush is high is ignored for both update and mispredict (wrong-path instruction). At most one flush per two cycles.
- **Stall:** not an input. Table updates and flush proceed regardless; the program counter gives flush priority over stall.
- **Reset** (sync, any time, including with a flush pending):
  - Next edge: all valid bits 0, ctr 00, flush 0, flush_address 0.
  - res_valid during reset is ignored.
- **Reset values:** take_branch 0, branch_predict fetch_pc+2, flush 0, flush_address 0.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- Defined: adds outputs stat_resolved and stat_mispredict, each 16 bits.
  - Each increments on a counted resolve / mispredict and saturates at 16'hFFFF.
  - Cleared by reset.
  - Resolves ignored during a flush cycle are not counted.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared defines (`defines.vh`): ADDR_WIDTH and counter encodings BP_SNT/BP_WNT/BP_WT/BP_ST.
- Sub-module btb_table holds storage: async read port, one sync write port, sync bulk clear.
- branch_predictor holds counter update, mispredict detect and the flush register.

Test Plan:
- **Cold miss:** After reset, fetch_pc=0x0010 -> take_branch=0, branch_predict=0x0012.
- **Allocate then predict:** res_valid, res_pc=0x0010, res_taken=1, res_target=0x0040, res_pred_taken=0 ->
  - next cycle flush=1, flush_address=0x0040;
  - fetch_pc=0x0010 then gives take_branch=1, branch_predict=0x0040.
- **Saturation:** 3 more taken resolves at 0x0010 -> ctr=11. Two not-taken resolves -> ctr=01, take_branch=0.
  - The first not-taken resolve (res_pred_taken=1) flushes to 0x0012. The second (pred_taken=0) does not.
- **Alias:** entry at 0x0010 valid; resolve taken at 0x0030 (same index, different tag) -> replaces entry.
  - Lookup at 0x0010 is now a miss.
- **Target mismatch:** pred_taken=1, pred_target=0x0040, actual taken to 0x0050 -> flush to 0x0050.
  - A resolve in the flush cycle is ignored: no update, no flush.
- **Reset mid-flush:** mispredict, then reset asserted the next cycle -> flush 0 at the following edge, table invalid.
  - Wrap: a not-taken mispredict at 0xFFFE gives flush_address 0x0000.
